vga_pattern_gen: RTL and testbench

Parametrised successor to the single-pattern VGA FSM. Integrates horizontal/vertical timing counters, sync generation, frame-synchronous mode switching, cell-grid counters and pattern colouring into one registered pixel pipeline. Sits between the game/memory logic, which supplies a display mode, and the VGA DAC pins. Colour depth, timing and grid cell size are parameters.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing.sv | 88 ++++++++
 rtl/vga_pattern_gen.sv | 134 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA pattern generator.
package vga_pkg;

    typedef enum logic [2:0] {
        MODE_BLACK   = 3'd0,
        MODE_WHITE   = 3'd1,
        MODE_COLBARS = 3'd2,
        MODE_ROWBARS = 3'd3,
        MODE_COLGRID = 3'd4,
        MODE_ROWGRID = 3'd5,
        MODE_GREEN   = 3'd6,
        MODE_RED     = 3'd7
    } mode_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned CELL_W = 6;

    function automatic int unsigned calc_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage-0 VGA timing: pixel/line counters, cell-grid counters and raw
// sync/active/frame_start/re decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CELL     = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  row,
    output logic [CELL_W-1:0] ccol,
    output logic [CELL_W-1:0] crow,
    output logic              hsync_c,
    output logic              vsync_c,
    output logic              active_c,
    output logic              frame_start,
    output logic              re
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  H_SS       = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  H_SE       = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]  V_SS       = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  V_SE       = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0]  V_PRE_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CELL_W-1:0] CELL_LAST  = CELL_W'(CELL - 1);

    logic line_end;
    logic frame_end;

    assign line_end  = (col == H_LAST);
    assign frame_end = (row == V_LAST);

    // Pixel and line counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= line_end ? '0 : col + 1'b1;
            if (line_end) begin
                row <= frame_end ? '0 : row + 1'b1;
            end
        end
    end

    // Cell counters track col/row modulo CELL without a divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccol <= '0;
            crow <= '0;
        end else begin
            if (line_end) begin
                ccol <= '0;
                if (frame_end || crow == CELL_LAST) begin
                    crow <= '0;
                end else begin
                    crow <= crow + 1'b1;
                end
            end else begin
                ccol <= (ccol == CELL_LAST) ? '0 : ccol + 1'b1;
            end
        end
    end

    assign hsync_c     = !((col >= H_SS) && (col < H_SE));
    assign vsync_c     = !((row >= V_SS) && (row < V_SE));
    assign active_c    = (col < H_VIS) && (row < V_VIS);
    assign frame_start = (col == '0) && (row == '0);
    // Prefetch strobe at the end of every line that precedes a visible line
    assign re          = line_end && ((row < V_PRE_LAST) || frame_end);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: timing, frame-synchronous mode switch and a
// one-clock registered colour/sync pipeline. Optional macro: VGA_BORDER_EN.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned COLOR_W  = 1,
    parameter int unsigned CELL     = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         mode_in,
    input  logic               mode_valid,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hsync,
    output logic               vsync,
    output logic [CNT_W-1:0]   col,
    output logic [CNT_W-1:0]   row,
    output logic               active,
    output logic               frame_start,
    output logic               re
);

    logic [CELL_W-1:0] ccol;
    logic [CELL_W-1:0] crow;
    logic              hsync_c;
    logic              vsync_c;
    logic              active_c;
    mode_t             pend_mode;
    mode_t             cur_mode;
    mode_t             eff_mode_c;
    logic [2:0]        px_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CELL     (CELL)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .col         (col),
        .row         (row),
        .ccol        (ccol),
        .crow        (crow),
        .hsync_c     (hsync_c),
        .vsync_c     (vsync_c),
        .active_c    (active_c),
        .frame_start (frame_start),
        .re          (re)
    );

    // Mode in force for this pixel; a strobe on frame_start takes effect at once
    always_comb begin
        eff_mode_c = cur_mode;
        if (frame_start) begin
            eff_mode_c = mode_valid ? mode_t'(mode_in) : pend_mode;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_mode <= MODE_BLACK;
            cur_mode  <= MODE_BLACK;
        end else begin
            if (mode_valid) begin
                pend_mode <= mode_t'(mode_in);
            end
            cur_mode <= eff_mode_c;
        end
    end

`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_ACTIVE - 1);
`endif

    // Pattern colour as {r,g,b} single bits
    always_comb begin
        px_c = 3'b000;
        case (eff_mode_c)
            MODE_BLACK:   px_c = 3'b000;
            MODE_WHITE:   px_c = 3'b111;
            MODE_COLBARS: px_c = col[2:0];
            MODE_ROWBARS: px_c = row[2:0];
            MODE_COLGRID: px_c = {3{ccol == '0}};
            MODE_ROWGRID: px_c = {3{crow == '0}};
            MODE_GREEN:   px_c = 3'b010;
            MODE_RED:     px_c = 3'b100;
            default:      px_c = 3'b000;
        endcase
`ifdef VGA_BORDER_EN
        if ((col == '0) || (col == H_VIS_LAST) || (row == '0) || (row == V_VIS_LAST)) begin
            px_c = 3'b111;
        end
`endif
        if (!active_c) begin
            px_c = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            active <= 1'b0;
        end else begin
            r      <= {COLOR_W{px_c[2]}};
            g      <= {COLOR_W{px_c[1]}};
            b      <= {COLOR_W{px_c[0]}};
            hsync  <= hsync_c;
            vsync  <= vsync_c;
            active <= active_c;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen using a reduced raster and a
// frame-level behavioural model; honours VGA_BORDER_EN.
module tb_vga_pattern_gen;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int CW = 4, CL = 7;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    mode_in;
    logic          mode_valid;
    logic [CW-1:0] r, g, b;
    logic          hsync, vsync, active, frame_start, re;
    logic [9:0]    col, row;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .COLOR_W  (CW), .CELL (CL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_in     (mode_in),
        .mode_valid  (mode_valid),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .col         (col),
        .row         (row),
        .active      (active),
        .frame_start (frame_start),
        .re          (re)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference colour of pixel (c,rw) under mode m, as {r,g,b} bits
    function automatic logic [2:0] model_rgb(input int m, input int c, input int rw);
        if (!(c < HA && rw < VA)) return 3'b000;
`ifdef VGA_BORDER_EN
        if (c == 0 || c == HA - 1 || rw == 0 || rw == VA - 1) return 3'b111;
`endif
        case (m)
            0:       return 3'b000;
            1:       return 3'b111;
            2:       return 3'(c % 8);
            3:       return 3'(rw % 8);
            4:       return (c % CL == 0) ? 3'b111 : 3'b000;
            5:       return (rw % CL == 0) ? 3'b111 : 3'b000;
            6:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Mode in force for a pixel: frames latch the latest request at their first pixel
    function automatic int model_eff(input int c, input int rw, input logic v,
                                     input int mi, input int last, input int cur);
        if (c == 0 && rw == 0) return v ? mi : last;
        return cur;
    endfunction

    int         m_col, m_row, m_mode, m_last;
    logic [2:0] e_rgb;
    logic       e_hs, e_vs, e_act;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_col  <= 0;
            m_row  <= 0;
            m_mode <= 0;
            m_last <= 0;
            e_rgb  <= 3'b000;
            e_hs   <= 1'b1;
            e_vs   <= 1'b1;
            e_act  <= 1'b0;
        end else begin
            m_mode <= model_eff(m_col, m_row, mode_valid, int'(mode_in), m_last, m_mode);
            if (mode_valid) m_last <= int'(mode_in);
            e_rgb <= model_rgb(model_eff(m_col, m_row, mode_valid, int'(mode_in), m_last, m_mode),
                               m_col, m_row);
            e_hs  <= !(m_col >= HA + HF && m_col < HA + HF + HS);
            e_vs  <= !(m_row >= VA + VF && m_row < VA + VF + VS);
            e_act <= (m_col < HA) && (m_row < VA);
            m_col <= (m_col + 1) % HT;
            if (m_col == HT - 1) m_row <= (m_row + 1) % VT;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pixel", {r, g, b, hsync, vsync, active},
                  {{CW{e_rgb[2]}}, {CW{e_rgb[1]}}, {CW{e_rgb[0]}}, e_hs, e_vs, e_act});
            check("counters", {col, row, frame_start, re},
                  {10'(m_col), 10'(m_row), (m_col == 0 && m_row == 0),
                   (m_col == HT - 1) && ((m_row + 1 < VA) || (m_row == VT - 1))});
        end
    end

    int cyc    = 0;
    int re_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (re && reset_n) re_cnt <= re_cnt + 1;
    end

    task automatic wait_pos(input int c, input int rw);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (col == 10'(c) && row == 10'(rw)) found = 1'b1;
        end
        if (!found) begin
            n_chk++;
            $display("FAIL wait_pos: col/row %0d/%0d never reached, got %0d/%0d", c, rw, col, row);
        end
    endtask

    task automatic scan_line(input int rw, output int white, output int hs_low, output int act);
        white = 0; hs_low = 0; act = 0;
        wait_pos(0, rw);
        repeat (HT) begin
            @(negedge clk);
            if (active && r == '1 && g == '1 && b == '1) white++;
            if (!hsync) hs_low++;
            if (active) act++;
        end
    endtask

    task automatic pulse(input logic [2:0] m);
        mode_in    = m;
        mode_valid = 1'b1;
        @(negedge clk);
        mode_valid = 1'b0;
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, r0, w, hl, a;
        reset_n    = 1'b0;
        mode_valid = 1'b0;
        mode_in    = 3'd0;
        #2 chk_en  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Frame period and prefetch count
        wait_pos(0, 0);
        t0 = cyc; r0 = re_cnt;
        @(negedge clk);
        wait_pos(0, 0);
        check("frame_period", 64'(cyc - t0), 64'(FRAME));
        check("re_per_frame", 64'(re_cnt - r0), 64'(VA));

        // Sync placement
        wait_pos(HA + HF, 5);
        check("hsync_pre_window", 64'(hsync), 64'(1));
        @(negedge clk);
        check("hsync_first_low", 64'(hsync), 64'(0));
        scan_line(6, w, hl, a);
        check("hsync_width", 64'(hl), 64'(HS));
        check("active_per_line", 64'(a), 64'(HA));
        wait_pos(2, VA + VF - 1);
        check("vsync_before", 64'(vsync), 64'(1));
        wait_pos(2, VA + VF);
        check("vsync_low_first", 64'(vsync), 64'(0));
        wait_pos(2, VA + VF + 1);
        check("vsync_low_last", 64'(vsync), 64'(0));
        wait_pos(2, VA + VF + 2);
        check("vsync_after", 64'(vsync), 64'(1));

        // Colbars request mid-frame waits for the next frame
        wait_pos(3, 10);
        pulse(3'd2);
        wait_pos(5, 20);
        @(negedge clk);
        check("mode_held_until_frame", 64'({r, g, b}), 64'(0));
        wait_pos(5, 1);
        @(negedge clk);
        check("colbars_col5", 64'({r, g, b}), 64'({4'hF, 4'h0, 4'hF}));

        // Column grid
        wait_pos(3, 10);
        pulse(3'd4);
        scan_line(3, w, hl, a);
`ifdef VGA_BORDER_EN
        check("colgrid_whites", 64'(w), 64'(7));
`else
        check("colgrid_whites", 64'(w), 64'(6));
`endif

        // Row grid
        wait_pos(3, 10);
        pulse(3'd5);
        wait_pos(0, 0);
        scan_line(2 * CL, w, hl, a);
        check("rowgrid_white_row", 64'(w), 64'(HA));
        scan_line(2 * CL + 1, w, hl, a);
`ifdef VGA_BORDER_EN
        check("rowgrid_plain_row", 64'(w), 64'(2));
`else
        check("rowgrid_plain_row", 64'(w), 64'(0));
`endif

        // Strobe on the frame_start cycle wins over earlier requests
        wait_pos(3, 5);
        pulse(3'd6);
        wait_pos(3, 8);
        pulse(3'd7);
        wait_pos(0, 0);
        pulse(3'd1);
        wait_pos(3, 2);
        @(negedge clk);
        check("frame_start_strobe_white", 64'({r, g, b}), 64'({4'hF, 4'hF, 4'hF}));

        // Last of several requests wins
        wait_pos(3, 5);
        pulse(3'd6);
        wait_pos(3, 8);
        pulse(3'd7);
        wait_pos(10, 5);
        @(negedge clk);
        check("last_write_red", 64'({r, g, b}), 64'({4'hF, 4'h0, 4'h0}));
        wait_pos(45, 5);
        @(negedge clk);
        check("blank_pixel", 64'({r, g, b, active}), 64'(0));

        // Randomised mode requests
        repeat (3 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 2) begin
                mode_in    = 3'($urandom_range(0, 7));
                mode_valid = 1'b1;
            end else begin
                mode_valid = 1'b0;
            end
        end
        mode_valid = 1'b0;

        // Asynchronous reset in the middle of a red frame
        wait_pos(3, 10);
        pulse(3'd7);
        wait_pos(20, 15);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rgb", 64'({r, g, b}), 64'(0));
        check("async_rst_syncs", 64'({hsync, vsync, active}), 64'(3'b110));
        check("async_rst_pos", 64'({col, row}), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_pos(3, 2);
        @(negedge clk);
        check("mode_black_after_reset", 64'({r, g, b}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
